io_bus_dma: RTL and testbench

Single-channel memory-to-memory copy engine that acts as an initiator on the peripheral IO bus, i.e. the requesting end of the io_addr / io_read / io_write / read_ready / io_ready handshake that the peripheral bus decoder and its flash, SDRAM, GPIO and UART responders serve. It reads `len` units from a source address and writes each to a destination address, one transaction at a time. It reports progress, completion and errors to the core-side control logic. It sits beside the core's load/store path in front of the peripheral bus arbiter.

---
 rtl/io_bus_dma.sv | 273 +++++++++++++++++++++++++++
 tb/tb_io_bus_dma.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_dma.sv
// io_bus_dma
// Single-channel memory-to-memory copy engine. It is an initiator on the
// peripheral IO bus. Each unit is one read transaction from src followed by
// one write transaction of the same data to dst. The addresses advance by
// the unit size and wrap modulo 2^XLEN.
//
// Ports
//   pclk, rst          clock (rising edge), asynchronous active-high reset
//   start              one-cycle request, sampled only while idle
//   abort              level; stop after the unit currently in flight
//   src_addr/dst_addr  start addresses, latched on an accepted start
//   len                number of units to copy
//   byte_size          0=byte 1=half 2=word (3 is rejected as misaligned)
//   busy               high from accepted start until back in idle
//   done               one-cycle pulse on any termination
//   err_timeout/err_align/aborted  sticky status, cleared on accepted start
//   units_done         units fully written in the current/last transfer
//   io_addr/io_read/io_write/io_wdata/io_byte_size/read_ready  bus request side
//   io_rdata/io_ready  bus response side
module io_bus_dma #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] src_addr,
    input  logic [XLEN-1:0] dst_addr,
    input  logic [15:0]     len,
    input  logic [1:0]      byte_size,
    output logic            busy,
    output logic            done,
    output logic            err_timeout,
    output logic            err_align,
    output logic            aborted,
    output logic [15:0]     units_done,
    output logic [XLEN-1:0] io_addr,
    output logic            io_read,
    output logic            io_write,
    output logic [XLEN-1:0] io_wdata,
    output logic [1:0]      io_byte_size,
    output logic            read_ready,
    input  logic [XLEN-1:0] io_rdata,
    input  logic            io_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RD_ACK = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_WR_END = 3'd4;

    // The phase counter holds the number of already-waited cycles, so a phase
    // expires on the edge where it has been active TIMEOUT_CYCLES cycles.
    localparam logic [15:0] PHASE_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state_q,  state_d;
    logic [XLEN-1:0] src_q,    src_d;
    logic [XLEN-1:0] dst_q,    dst_d;
    logic [XLEN-1:0] buf_q,    buf_d;
    logic [XLEN-1:0] addr_q,   addr_d;
    logic [15:0]     remain_q, remain_d;
    logic [15:0]     units_q,  units_d;
    logic [15:0]     phase_q,  phase_d;
    logic [1:0]      bsize_q,  bsize_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic            rd_q,     rd_d;
    logic            wr_q,     wr_d;
    logic            rr_q,     rr_d;
    logic            err_to_q, err_to_d;
    logic            err_al_q, err_al_d;
    logic            abrt_q,   abrt_d;

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] src_next;
    logic [XLEN-1:0] dst_next;
    logic            misaligned;
    logic            phase_expired;
    logic            fail;

    assign step          = {{(XLEN-1){1'b0}}, 1'b1} << bsize_q;
    assign src_next      = src_q + step;
    assign dst_next      = dst_q + step;
    assign phase_expired = (phase_q == PHASE_LAST);

    // Alignment is judged on the request inputs, before anything is latched.
    always_comb begin
        case (byte_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = src_addr[0] | dst_addr[0];
            2'd2:    misaligned = (|src_addr[1:0]) | (|dst_addr[1:0]);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        units_d  = units_q;
        phase_d  = phase_q + 16'd1;
        bsize_d  = bsize_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rr_d     = rr_q;
        err_to_d = err_to_q;
        err_al_d = err_al_q;
        abrt_d   = abrt_q;
        fail     = 1'b0;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (start) begin
                    if (misaligned) begin
                        // Rejected request: report it but leave the
                        // results of the previous transfer untouched.
                        err_al_d = 1'b1;
                        done_d   = 1'b1;
                    end else if (len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d    = src_addr;
                        dst_d    = dst_addr;
                        remain_d = len;
                        bsize_d  = byte_size;
                        units_d  = '0;
                        err_to_d = 1'b0;
                        err_al_d = 1'b0;
                        abrt_d   = 1'b0;
                        busy_d   = 1'b1;
                        rd_d     = 1'b1;
                        addr_d   = src_addr;
                        state_d  = S_RD;
                    end
                end
            end
            S_RD: begin
                if (io_ready) begin
                    buf_d   = io_rdata;
                    rd_d    = 1'b0;
                    rr_d    = 1'b1;
                    phase_d = '0;
                    state_d = S_RD_ACK;
                end else if (phase_expired) begin
                    fail = 1'b1;
                end
            end
            S_RD_ACK: begin
                if (!io_ready) begin
                    rr_d    = 1'b0;
                    wr_d    = 1'b1;
                    addr_d  = dst_q;
                    phase_d = '0;
                    state_d = S_WR;
                end else if (phase_expired) begin
                    fail = 1'b1;
                end
            end
            S_WR: begin
                if (io_ready) begin
                    wr_d    = 1'b0;
                    phase_d = '0;
                    state_d = S_WR_END;
                end else if (phase_expired) begin
                    fail = 1'b1;
                end
            end
            S_WR_END: begin
                if (!io_ready) begin
                    // Unit boundary: the only place abort is honoured.
                    units_d  = units_q + 16'd1;
                    src_d    = src_next;
                    dst_d    = dst_next;
                    remain_d = remain_q - 16'd1;
                    phase_d  = '0;
                    if (remain_q == 16'd1 || abort) begin
                        abrt_d  = abort && (remain_q != 16'd1);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        rd_d    = 1'b1;
                        addr_d  = src_next;
                        state_d = S_RD;
                    end
                end else if (phase_expired) begin
                    fail = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                rr_d    = 1'b0;
            end
        endcase

        if (fail) begin
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            rr_d     = 1'b0;
            err_to_d = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            phase_d  = '0;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            buf_q    <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            units_q  <= '0;
            phase_q  <= '0;
            bsize_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rr_q     <= 1'b0;
            err_to_q <= 1'b0;
            err_al_q <= 1'b0;
            abrt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            buf_q    <= buf_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            units_q  <= units_d;
            phase_q  <= phase_d;
            bsize_q  <= bsize_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rr_q     <= rr_d;
            err_to_q <= err_to_d;
            err_al_q <= err_al_d;
            abrt_q   <= abrt_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_to_q;
    assign err_align    = err_al_q;
    assign aborted      = abrt_q;
    assign units_done   = units_q;
    assign io_addr      = addr_q;
    assign io_read      = rd_q;
    assign io_write     = wr_q;
    // The buffer only changes on a read capture, so it is stable through WR.
    assign io_wdata     = buf_q;
    assign io_byte_size = bsize_q;
    assign read_ready   = rr_q;

endmodule

// File: tb/tb_io_bus_dma.sv
// tb_io_bus_dma
// Bench for io_bus_dma: a programmable-latency responder, a bus monitor,
// a table of directed transfers, randomized transfers checked against a
// transfer-level model, and hand-written timeout / reset sequences.
module tb_io_bus_dma;

    localparam int TO     = 8;
    localparam int BUDGET = 300;

    logic        pclk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic [1:0]  byte_size;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_align;
    logic        aborted;
    logic [15:0] units_done;
    logic [31:0] io_addr;
    logic        io_read;
    logic        io_write;
    logic [31:0] io_wdata;
    logic [1:0]  io_byte_size;
    logic        read_ready;
    logic [31:0] io_rdata;
    logic        io_ready;

    io_bus_dma #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .rst(rst), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .byte_size(byte_size),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_align(err_align),
        .aborted(aborted), .units_done(units_done), .io_addr(io_addr),
        .io_read(io_read), .io_write(io_write), .io_wdata(io_wdata),
        .io_byte_size(io_byte_size), .read_ready(read_ready),
        .io_rdata(io_rdata), .io_ready(io_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [31:0] rdata_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Responder: ready after `lat` wait cycles, then holds io_ready for
    // `hold` extra cycles after the strobe drops; `never` keeps it low.
    int lat;
    int hold;
    bit never;
    int wait_q;
    int tail_q;

    always @(posedge pclk or posedge rst) begin
        if (rst) begin
            wait_q <= 0;
            tail_q <= 0;
        end else begin
            wait_q <= (io_read || io_write) ? wait_q + 1 : 0;
            if ((io_read || io_write) && io_ready) tail_q <= hold;
            else if (tail_q > 0) tail_q <= tail_q - 1;
        end
    end

    always_comb begin
        io_ready = !never && ((((io_read || io_write) && wait_q >= lat)) || tail_q > 0);
        io_rdata = rdata_fn(io_addr);
    end

    // Monitor: records completed bus transactions and protocol violations.
    logic [31:0] rd_addrs[$];
    logic [31:0] wr_addrs[$];
    logic [31:0] wr_datas[$];
    logic [1:0]  rd_bs[$];
    int done_cnt;
    int overlap_cnt;

    initial begin
        done_cnt    = 0;
        overlap_cnt = 0;
    end

    always @(posedge pclk) begin
        if (!rst) begin
            if (io_read && io_ready) begin
                rd_addrs.push_back(io_addr);
                rd_bs.push_back(io_byte_size);
            end
            if (io_write && io_ready) begin
                wr_addrs.push_back(io_addr);
                wr_datas.push_back(io_wdata);
            end
            if ((io_read && io_write) || (io_read && read_ready)) overlap_cnt <= overlap_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transfer-level model state (sticky status and last unit count).
    int m_units;
    bit m_al;
    bit m_to;
    bit m_ab;

    task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           input logic [1:0] bs, input int la, input int ho, input int ab_k,
                           input bit poke, input bit stuck, output int cycles);
        int step;
        int n;
        int rb;
        int wb;
        int db;
        int ob;
        int exp_cyc;
        bit mis;
        bit accepted;
        logic busy0;
        lat   = la;
        hold  = ho;
        never = stuck;
        rb = rd_addrs.size();
        wb = wr_addrs.size();
        db = done_cnt;
        ob = overlap_cnt;

        step     = 1 << bs;
        mis      = (bs == 2'd3) || (s % 32'(step) != 0) || (d % 32'(step) != 0);
        accepted = !mis && (l != 16'd0);
        n = 0;
        if (mis) begin
            m_al = 1'b1;
        end else if (accepted) begin
            m_al = 1'b0;
            m_to = 1'b0;
            m_ab = 1'b0;
            if (stuck) begin
                m_to = 1'b1;
            end else begin
                n    = (ab_k > 0 && ab_k < int'(l)) ? ab_k : int'(l);
                m_ab = (ab_k > 0 && ab_k < int'(l));
            end
            m_units = n;
        end
        if (!accepted)  exp_cyc = 0;
        else if (stuck) exp_cyc = TO;
        else            exp_cyc = n * (2 * la + 2 * ho + 4);

        @(negedge pclk);
        src_addr = s; dst_addr = d; len = l; byte_size = bs; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        busy0 = busy;
        cycles = 0;
        while (done !== 1'b1 && cycles < BUDGET) begin
            if (ab_k > 0 && rd_addrs.size() - rb >= ab_k) abort = 1'b1;
            if (poke && cycles == 1) begin
                start = 1'b1; src_addr = 32'hDEAD_0001; len = 16'd9; byte_size = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge pclk);
            cycles++;
        end
        start = 1'b0;
        abort = 1'b0;

        chk("done_within_budget", 32'(cycles < BUDGET), 32'd1);
        chk("busy_after_start", 32'(busy0), 32'(accepted));
        chk("busy_with_done", 32'(busy), 32'd0);
        chk("strobes_at_done", {29'd0, io_read, io_write, read_ready}, 32'd0);
        chk("cycles", cycles, exp_cyc);
        chk("units_done", 32'(units_done), m_units);
        chk("err_align", 32'(err_align), 32'(m_al));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        chk("aborted", 32'(aborted), 32'(m_ab));
        chk("read_count", rd_addrs.size() - rb, n);
        chk("write_count", wr_addrs.size() - wb, n);
        if (rd_addrs.size() - rb == n && wr_addrs.size() - wb == n) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] ea;
                logic [31:0] eb;
                ea = s + 32'(i * step);
                eb = d + 32'(i * step);
                chk("rd_addr", rd_addrs[rb + i], ea);
                chk("wr_addr", wr_addrs[wb + i], eb);
                chk("wr_data", wr_datas[wb + i], rdata_fn(ea));
                chk("bus_size", 32'(rd_bs[rb + i]), 32'(bs));
            end
        end
        @(negedge pclk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_pulses", done_cnt - db, 1);
        chk("strobe_overlap", overlap_cnt - ob, 0);
        $display("xfer src=%08h dst=%08h len=%0d bs=%0d lat=%0d hold=%0d abk=%0d cyc=%0d units=%0d",
                 s, d, l, bs, la, ho, ab_k, cycles, units_done);
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] l;
        logic [1:0]  bs;
        int          lat;
        int          hold;
        int          ab_k;
        bit          poke;
        int          e_units;
        int          e_cycles;
        bit          e_align;
        bit          e_abort;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int cyc;
        int rb;
        int wb;
        int db;
        logic [31:0] rs;
        logic [31:0] rd;
        logic [15:0] rl;
        logic [1:0]  rbs;
        int rstep;
        int rab;

        vecs[0]  = '{32'h0000_0100, 32'h0000_0200, 16'd3, 2'd2, 0, 0, 0, 1'b0, 3, 12, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0301, 32'h0000_0405, 16'd2, 2'd0, 2, 1, 0, 1'b0, 2, 20, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0102, 32'h0000_0200, 16'd4, 2'd2, 0, 0, 0, 1'b0, 2,  0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_1000, 32'h0000_2000, 16'd5, 2'd2, 0, 0, 2, 1'b0, 2,  8, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_0040, 32'hFFFF_FFFC, 16'd2, 2'd2, 0, 0, 0, 1'b0, 2,  8, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0010, 32'h0000_0020, 16'd0, 2'd1, 0, 0, 0, 1'b0, 2,  0, 1'b0, 1'b0};
        vecs[6]  = '{32'h0000_0002, 32'h0000_0006, 16'd4, 2'd1, 1, 0, 0, 1'b1, 4, 24, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 16'd1, 2'd3, 0, 0, 0, 1'b0, 4,  0, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0010, 32'h0000_0021, 16'd2, 2'd1, 0, 0, 0, 1'b0, 4,  0, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_0010, 32'h0000_0020, 16'd3, 2'd1, 0, 3, 3, 1'b0, 3, 30, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_0007, 32'h0000_0009, 16'd1, 2'd0, 3, 0, 1, 1'b0, 1, 10, 1'b0, 1'b0};

        total = 0; bad = 0;
        m_units = 0; m_al = 1'b0; m_to = 1'b0; m_ab = 1'b0;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; byte_size = '0;
        lat = 0; hold = 0; never = 1'b0;

        #1 rst = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobes", {29'd0, io_read, io_write, read_ready}, 32'd0);
        chk("rst_io_addr", io_addr, 32'd0);
        chk("rst_io_wdata", io_wdata, 32'd0);
        chk("rst_io_byte_size", 32'(io_byte_size), 32'd0);
        chk("rst_units_done", 32'(units_done), 32'd0);
        chk("rst_status", {29'd0, err_timeout, err_align, aborted}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_xfer(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].bs, vecs[i].lat, vecs[i].hold,
                    vecs[i].ab_k, vecs[i].poke, 1'b0, cyc);
            chk("tbl_cycles", cyc, vecs[i].e_cycles);
            chk("tbl_units", 32'(units_done), vecs[i].e_units);
            chk("tbl_align", 32'(err_align), 32'(vecs[i].e_align));
            chk("tbl_abort", 32'(aborted), 32'(vecs[i].e_abort));
        end

        // Responder never answers a read: the read phase expires.
        do_xfer(32'h500, 32'h600, 16'd3, 2'd2, 0, 0, 0, 1'b0, 1'b1, cyc);
        never = 1'b0;

        // Responder keeps io_ready high after the read: RD_ACK expires.
        lat = 0; hold = 30;
        rb = rd_addrs.size(); wb = wr_addrs.size();
        @(negedge pclk);
        src_addr = 32'h700; dst_addr = 32'h800; len = 16'd2; byte_size = 2'd2; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(negedge pclk);
            cyc++;
        end
        chk("ack_to_cycles", cyc, 9);
        chk("ack_to_err", 32'(err_timeout), 32'd1);
        chk("ack_to_units", 32'(units_done), 32'd0);
        chk("ack_to_read_ready", 32'(read_ready), 32'd0);
        chk("ack_to_reads", rd_addrs.size() - rb, 1);
        chk("ack_to_writes", wr_addrs.size() - wb, 0);
        $display("ack timeout cyc=%0d err_timeout=%0d", cyc, err_timeout);
        hold = 0;
        repeat (40) @(negedge pclk);
        m_to = 1'b1; m_al = 1'b0; m_ab = 1'b0; m_units = 0;

        // Randomized transfers against the model.
        for (int t = 0; t < 40; t++) begin
            rbs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rstep = 1 << rbs;
            rs = $urandom;
            rd = $urandom;
            if (t % 6 == 0) rd = 32'hFFFF_FFF8;
            if ($urandom_range(0, 3) != 0) begin
                rs = rs - (rs % 32'(rstep));
                rd = rd - (rd % 32'(rstep));
            end
            rl  = 16'($urandom_range(0, 5));
            rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rl) + 1)) : 0;
            do_xfer(rs, rd, rl, rbs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    rab, 1'($urandom_range(0, 3) == 0), 1'b0, cyc);
        end

        // Reset asserted during the second unit's write phase.
        lat = 0; hold = 0;
        @(negedge pclk);
        src_addr = 32'h40; dst_addr = 32'h80; len = 16'd3; byte_size = 2'd2; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        cyc = 0;
        while (!(io_write === 1'b1 && units_done == 16'd1) && cyc < 50) begin
            @(negedge pclk);
            cyc++;
        end
        chk("mid_wr_reached", 32'(io_write), 32'd1);
        db = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_write", 32'(io_write), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", io_addr, 32'd0);
        chk("mid_rst_units", 32'(units_done), 32'd0);
        repeat (2) @(negedge pclk);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge pclk);
        chk("mid_rst_no_done", done_cnt - db, 0);
        $display("reset mid-write io_write=%0d busy=%0d", io_write, busy);
        m_units = 0; m_al = 1'b0; m_to = 1'b0; m_ab = 1'b0;

        do_xfer(32'h44, 32'hFFFF_FFFC, 16'd2, 2'd2, 0, 0, 0, 1'b0, 1'b0, cyc);
        chk("post_rst_cycles", cyc, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
